// File: rtl/car_lane_left.sv
// car_lane_left: one lane of three cars that drift left across a grid row
// and wrap from column 0 back to MAX_X. The cars share one step timer, the
// lane can be paused, and it flags a frog standing on any car in its row.
module car_lane_left #(
    parameter int unsigned CLKS_PER_STEP = 12500000,
    parameter int unsigned MAX_X         = 20,
    parameter int unsigned LANE_Y        = 1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic [4:0] i_car0_x,
    input  logic [4:0] i_car1_x,
    input  logic [4:0] i_car2_x,
    input  logic [1:0] i_speed,
    input  logic       i_pause,
    input  logic [4:0] i_frog_x,
    input  logic [3:0] i_frog_y,
    output logic [4:0] o_car0_x,
    output logic [4:0] o_car1_x,
    output logic [4:0] o_car2_x,
    output logic       o_running,
    output logic       o_step,
    output logic       o_hit
);

    localparam logic [4:0]  MaxCol  = 5'(MAX_X);
    localparam logic [3:0]  LaneRow = 4'(LANE_Y);
    localparam logic [31:0] BasePer = 32'(CLKS_PER_STEP);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2
    } state_e;

    state_e      state;
    logic [31:0] counter;
    logic [4:0]  car_x [3];
    logic        running;
    logic        step;
    logic        hit;

    logic [4:0]  start_x   [3];
    logic [4:0]  clamped_x [3];
    logic [4:0]  moved_x   [3];
    logic [31:0] period_raw;
    logic [31:0] period;
    logic        step_due;
    logic        frog_on_car;

    assign start_x[0] = i_car0_x;
    assign start_x[1] = i_car1_x;
    assign start_x[2] = i_car2_x;

    // Step period follows i_speed every cycle; a zero period means move every cycle.
    always_comb begin
        period_raw = BasePer >> i_speed;
        period     = (period_raw == 32'd0) ? 32'd1 : period_raw;
        // >= rather than == so a speed-up past the current count fires at once
        step_due   = (counter >= (period - 32'd1));
    end

    // Start-column clamping and the one-column-left move with wrap.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            clamped_x[i] = (start_x[i] > MaxCol) ? MaxCol : start_x[i];
            moved_x[i]   = (car_x[i] == 5'd0) ? MaxCol : (car_x[i] - 5'd1);
        end
    end

    // Frog is on this row and shares a column with at least one car.
    always_comb begin
        frog_on_car = 1'b0;
        if (i_frog_y == LaneRow) begin
            for (int i = 0; i < 3; i++) begin
                if (i_frog_x == car_x[i]) begin
                    frog_on_car = 1'b1;
                end
            end
        end
    end

    // Lane FSM: reset beats start, start beats pause and any pending step.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state   <= StIdle;
            counter <= 32'd0;
            for (int i = 0; i < 3; i++) begin
                car_x[i] <= 5'd0;
            end
            running <= 1'b0;
            step    <= 1'b0;
            hit     <= 1'b0;
        end else begin
            // Collision is judged against the positions currently on the outputs.
            hit <= running & frog_on_car;
            if (i_Start) begin
                state   <= StRun;
                counter <= 32'd0;
                for (int i = 0; i < 3; i++) begin
                    car_x[i] <= clamped_x[i];
                end
                running <= 1'b1;
                step    <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        counter <= 32'd0;
                        running <= 1'b0;
                        step    <= 1'b0;
                    end
                    // Releasing pause counts in the same cycle, so a count held at
                    // N resumes exactly where it left off.
                    StRun, StPaused: begin
                        running <= 1'b1;
                        if (i_pause) begin
                            state <= StPaused;
                            step  <= 1'b0;
                        end else begin
                            state <= StRun;
                            if (step_due) begin
                                counter <= 32'd0;
                                for (int i = 0; i < 3; i++) begin
                                    car_x[i] <= moved_x[i];
                                end
                                step <= 1'b1;
                            end else begin
                                counter <= counter + 32'd1;
                                step    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state   <= StIdle;
                        counter <= 32'd0;
                        running <= 1'b0;
                        step    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_car0_x  = car_x[0];
    assign o_car1_x  = car_x[1];
    assign o_car2_x  = car_x[2];
    assign o_running = running;
    assign o_step    = step;
    assign o_hit     = hit;

endmodule

// File: tb/tb_car_lane_left.sv
// Bench for car_lane_left with CLKS_PER_STEP=4, MAX_X=20, LANE_Y=1.
module tb_car_lane_left;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] c0, c1, c2;
    logic [1:0] speed;
    logic       pause;
    logic [4:0] fx;
    logic [3:0] fy;
    logic [4:0] o0, o1, o2;
    logic       running, step, hit;

    int checks = 0;
    int errors = 0;

    car_lane_left #(
        .CLKS_PER_STEP(4),
        .MAX_X(20),
        .LANE_Y(1)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Start(start),
        .i_car0_x(c0),
        .i_car1_x(c1),
        .i_car2_x(c2),
        .i_speed(speed),
        .i_pause(pause),
        .i_frog_x(fx),
        .i_frog_y(fy),
        .o_car0_x(o0),
        .o_car1_x(o1),
        .o_car2_x(o2),
        .o_running(running),
        .o_step(step),
        .o_hit(hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: each car is its start column minus the number of steps taken,
    // modulo the 21 legal columns; the timer is just "ticks since last step".
    int m_start [3];
    int m_steps;
    int m_elapsed;
    bit m_run, m_step, m_hit;

    function automatic int mpos(int i);
        return (m_start[i] + 21 - (m_steps % 21)) % 21;
    endfunction

    task automatic model_step();
        int  per;
        bit  hn;
        hn = m_run && (int'(fy) == 1) &&
             (int'(fx) == mpos(0) || int'(fx) == mpos(1) || int'(fx) == mpos(2));
        if (rst) begin
            for (int i = 0; i < 3; i++) m_start[i] = 0;
            m_steps = 0; m_elapsed = 0; m_run = 0; m_step = 0; m_hit = 0;
        end else begin
            m_hit = hn;
            if (start) begin
                m_start[0] = (int'(c0) > 20) ? 20 : int'(c0);
                m_start[1] = (int'(c1) > 20) ? 20 : int'(c1);
                m_start[2] = (int'(c2) > 20) ? 20 : int'(c2);
                m_steps = 0; m_elapsed = 0; m_run = 1; m_step = 0;
            end else if (m_run && !pause) begin
                per = 4 >> int'(speed);
                if (per < 1) per = 1;
                if (m_elapsed + 1 >= per) begin
                    m_elapsed = 0; m_steps++; m_step = 1;
                end else begin
                    m_elapsed++; m_step = 0;
                end
            end else begin
                m_step = 0;
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, DUT outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_car0", int'(o0), mpos(0));
        chk("model_car1", int'(o1), mpos(1));
        chk("model_car2", int'(o2), mpos(2));
        chk("model_running", int'(running), int'(m_run));
        chk("model_step", int'(step), int'(m_step));
        chk("model_hit", int'(hit), int'(m_hit));
    endtask

    task automatic pulse_start(int a, int b, int c);
        start = 1'b1; c0 = 5'(a); c1 = 5'(b); c2 = 5'(c);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_step(output int n);
        n = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (step) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct {
        bit rst, start;
        int c0, c1, c2, speed;
        bit pause;
        int fx, fy;
        int e0, e1, e2;
        bit erun, estep, ehit;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int n;
        rst = 0; start = 0; c0 = 0; c1 = 0; c2 = 0; speed = 0; pause = 0; fx = 0; fy = 0;

        //          rst st  c0 c1 c2 sp pa fx fy   e0 e1 e2 run stp hit
        vecs[0]  = '{1, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1,  5,10,15, 0, 0, 0, 0,   5,10,15, 1, 0, 0};
        vecs[2]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   5,10,15, 1, 0, 0};
        vecs[3]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   5,10,15, 1, 0, 0};
        vecs[4]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   5,10,15, 1, 0, 0};
        vecs[5]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   4, 9,14, 1, 1, 0};
        vecs[6]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   4, 9,14, 1, 0, 0};
        vecs[7]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   4, 9,14, 1, 0, 0};
        vecs[8]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   4, 9,14, 1, 0, 0};
        vecs[9]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,   3, 8,13, 1, 1, 0};
        vecs[10] = '{0, 1,  0,25, 9, 0, 0, 9, 1,   0,20, 9, 1, 0, 0};
        vecs[11] = '{0, 0,  0, 0, 0, 0, 0, 9, 1,   0,20, 9, 1, 0, 1};
        vecs[12] = '{0, 0,  0, 0, 0, 0, 0, 9, 2,   0,20, 9, 1, 0, 0};
        vecs[13] = '{0, 0,  0, 0, 0, 0, 0, 9, 1,   0,20, 9, 1, 0, 1};
        vecs[14] = '{0, 0,  0, 0, 0, 0, 0, 9, 1,  20,19, 8, 1, 1, 1};
        vecs[15] = '{0, 0,  0, 0, 0, 0, 0, 9, 1,  20,19, 8, 1, 0, 0};
        vecs[16] = '{1, 1,  7, 7, 7, 0, 1, 9, 1,   0, 0, 0, 0, 0, 0};
        vecs[17] = '{0, 0,  0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0};
        vecs[18] = '{0, 0,  0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst; start = vecs[i].start;
            c0 = 5'(vecs[i].c0); c1 = 5'(vecs[i].c1); c2 = 5'(vecs[i].c2);
            speed = 2'(vecs[i].speed); pause = vecs[i].pause;
            fx = 5'(vecs[i].fx); fy = 4'(vecs[i].fy);
            tick();
            chk($sformatf("vec%0d_car0", i), int'(o0), vecs[i].e0);
            chk($sformatf("vec%0d_car1", i), int'(o1), vecs[i].e1);
            chk($sformatf("vec%0d_car2", i), int'(o2), vecs[i].e2);
            chk($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].erun));
            chk($sformatf("vec%0d_step", i), int'(step), int'(vecs[i].estep));
            chk($sformatf("vec%0d_hit", i), int'(hit), int'(vecs[i].ehit));
        end
        rst = 0; start = 0; pause = 0; speed = 0; fx = 0; fy = 0;

        // Pause at count 2 for 10 cycles, then the step lands 2 cycles after release.
        pulse_start(5, 10, 15);
        tick(); tick();
        pause = 1'b1;
        repeat (10) tick();
        chk("pause_hold_car0", int'(o0), 5);
        chk("pause_hold_car2", int'(o2), 15);
        chk("pause_running", int'(running), 1);
        pause = 1'b0;
        wait_step(n);
        chk("pause_resume_latency", n, 2);
        chk("pause_resume_car0", int'(o0), 4);

        // Step spacing for each speed level.
        speed = 2'd1;
        wait_step(n);
        wait_step(n);
        chk("speed1_period", n, 2);
        speed = 2'd3;
        wait_step(n);
        wait_step(n);
        chk("speed3_period", n, 1);
        speed = 2'd2;
        wait_step(n);
        wait_step(n);
        chk("speed2_period", n, 1);

        // Speed-up when the count already exceeds the new period moves next cycle.
        speed = 2'd0;
        pulse_start(5, 10, 15);
        tick(); tick();
        speed = 2'd1;
        tick();
        chk("speedup_step", int'(step), 1);
        chk("speedup_car0", int'(o0), 4);

        // Reset mid-run at count 3 wipes the pending step.
        speed = 2'd0;
        pulse_start(5, 10, 15);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_reset_car1", int'(o1), 0);
        chk("midrun_reset_step", int'(step), 0);
        chk("midrun_reset_running", int'(running), 0);
        tick();
        chk("idle_after_reset_step", int'(step), 0);
        chk("idle_after_reset_car0", int'(o0), 0);

        // Start with pause high: load wins, pause applies the following cycle.
        pause = 1'b1;
        pulse_start(7, 8, 9);
        chk("start_pause_running", int'(running), 1);
        chk("start_pause_car0", int'(o0), 7);
        tick();
        chk("start_pause_hold", int'(o0), 7);
        pause = 1'b0;
        wait_step(n);
        chk("start_pause_resume", n, 4);

        // Randomized traffic against the reference.
        for (int k = 0; k < 600; k++) begin
            rst   = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 99) < 8);
            c0 = 5'($urandom_range(0, 31));
            c1 = 5'($urandom_range(0, 31));
            c2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
            fx = 5'($urandom_range(0, 21));
            fy = 4'($urandom_range(1, 2));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
